// File: rtl/trs80_video_pkg.sv
// trs80_video_pkg: timing, cell geometry and colour constants shared by the
// TRS-80 video generator, plus the block-graphics row decode.
package trs80_video_pkg;

  // Horizontal timing, in pixel ticks
  localparam logic [8:0] H_LAST   = 9'd511;
  localparam logic [8:0] H_ACTIVE = 9'd384;
  localparam logic [8:0] HS_START = 9'd416;
  localparam logic [8:0] HS_END   = 9'd464;

  // Vertical timing, in lines
  localparam logic [8:0] V_LAST   = 9'd311;
  localparam logic [8:0] V_ACTIVE = 9'd192;
  localparam logic [8:0] VS_START = 9'd240;
  localparam logic [8:0] VS_END   = 9'd244;

  // Character cell geometry; a wide cell spends two ticks on every glyph pixel
  localparam logic [3:0] CELL_W      = 4'd6;
  localparam logic [3:0] CELL_W_WIDE = 4'd12;
  localparam logic [3:0] CELL_H      = 4'd12;

  // Output colour levels
  localparam logic [5:0] FG_LEVEL = 6'd63;
  localparam logic [5:0] BG_LEVEL = 6'd0;

  // Per-tick attributes that travel down the fetch pipeline with the pixel
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic wide;
    logic phase;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1,
                                    wide: 1'b0, phase: 1'b0};

  // Block graphics: a cell is 2 wide x 3 tall; band = line_in_cell / 4.
  // Left three pixels take code[2*band], right three take code[2*band+1].
  function automatic logic [5:0] block_pattern(input logic [5:0] bits,
                                               input logic [1:0] band);
    logic left_on;
    logic right_on;
    left_on  = 1'b0;
    right_on = 1'b0;
    case (band)
      2'd0: begin left_on = bits[0]; right_on = bits[1]; end
      2'd1: begin left_on = bits[2]; right_on = bits[3]; end
      2'd2: begin left_on = bits[4]; right_on = bits[5]; end
      default: begin left_on = 1'b0; right_on = 1'b0; end
    endcase
    return {left_on, left_on, left_on, right_on, right_on, right_on};
  endfunction

endpackage

// File: rtl/trs80_char_shifter.sv
// trs80_char_shifter: per-cell pixel shift register. Loads either the glyph
// row from the character generator or a decoded block-graphics row, then
// shifts MSB first, holding each pixel for two ticks in wide mode.
module trs80_char_shifter
  import trs80_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       load,
  input  logic       block,
  input  logic [5:0] bits,
  input  logic [1:0] band,
  input  logic [5:0] glyph,
  input  logic       wide,
  input  logic       phase,
  output logic       pixel
);

  logic [5:0] shift_reg;
  logic [5:0] load_value;

  // Pick the row to load: decoded graphics blocks or the fetched glyph row
  always_comb begin
    load_value = glyph;
    if (block) begin
      load_value = block_pattern(bits, band);
    end
  end

  // Load at cell start, otherwise shift; wide mode shifts on the second tick only
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= 6'd0;
    end else if (ce_pix) begin
      if (load) begin
        shift_reg <= load_value;
      end else if (!wide || phase) begin
        shift_reg <= {shift_reg[4:0], 1'b0};
      end
    end
  end

  assign pixel = shift_reg[5];

endmodule

// File: rtl/trs80_video_gen.sv
// trs80_video_gen: TRS-80 Model I style 64x16 (or 32x16 wide) text and
// block-graphics video generator with a three-tick fetch pipeline.
// Optional feature macro: LOWERCASE_MOD_EN -- when defined, code bit 6 is
// used as fetched; otherwise text codes get bit 6 = ~bit 5 (no lowercase).
module trs80_video_gen
  import trs80_video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        wide,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] cg_addr,
  input  logic [5:0]  cg_data,
  output logic        hs,
  output logic        vs,
  output logic [5:0]  r,
  output logic [5:0]  g,
  output logic [5:0]  b
);

  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic [3:0] hsub;
  logic [5:0] char_col;
  logic [3:0] line_in_cell;
  logic [3:0] char_row;
  logic       wide_line;

  logic [3:0] cell_last;
  logic [5:0] col_step;
  logic       active_now;
  logic       cell_start;
  logic       hs_now;
  logic       vs_now;
  logic [7:0] fetched_code;

  stage_t     pipe1;
  stage_t     pipe2;
  stage_t     pipe3;
  logic       ld1;
  logic       ld2;
  logic [3:0] line1;
  logic       block2;
  logic [5:0] bits2;
  logic [1:0] band2;
  logic       pixel;
  logic [5:0] level;

  assign cell_last = wide_line ? (CELL_W_WIDE - 4'd1) : (CELL_W - 4'd1);
  assign col_step  = wide_line ? 6'd2 : 6'd1;

  // Raster counters plus cell-relative counters so no divider is needed
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt         <= 9'd0;
      vcnt         <= 9'd0;
      hsub         <= 4'd0;
      char_col     <= 6'd0;
      line_in_cell <= 4'd0;
      char_row     <= 4'd0;
      wide_line    <= 1'b0;
    end else if (ce_pix) begin
      if (hcnt == H_LAST) begin
        hcnt      <= 9'd0;
        hsub      <= 4'd0;
        char_col  <= 6'd0;
        wide_line <= wide;
        if (vcnt == V_LAST) begin
          vcnt         <= 9'd0;
          line_in_cell <= 4'd0;
          char_row     <= 4'd0;
        end else begin
          vcnt <= vcnt + 9'd1;
          if (line_in_cell == (CELL_H - 4'd1)) begin
            line_in_cell <= 4'd0;
            char_row     <= char_row + 4'd1;
          end else begin
            line_in_cell <= line_in_cell + 4'd1;
          end
        end
      end else begin
        hcnt <= hcnt + 9'd1;
        if (hsub == cell_last) begin
          hsub     <= 4'd0;
          char_col <= char_col + col_step;
        end else begin
          hsub <= hsub + 4'd1;
        end
      end
    end
  end

  // Decode the current raster position into active area, cell start and syncs
  always_comb begin
    active_now = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
    cell_start = active_now && (hsub == 4'd0);
    hs_now     = !((hcnt >= HS_START) && (hcnt < HS_END));
    vs_now     = !((vcnt >= VS_START) && (vcnt < VS_END));
  end

  // Character code as seen by the rest of the pipe, with optional lowercase mod
  always_comb begin
`ifdef LOWERCASE_MOD_EN
    fetched_code = vram_data;
`else
    fetched_code = vram_data;
    if (!vram_data[7]) begin
      fetched_code = {1'b0, ~vram_data[5], vram_data[5:0]};
    end
`endif
  end

  // Stage 1: present the video RAM address at cell start
  always_ff @(posedge clk) begin
    if (reset) begin
      ld1       <= 1'b0;
      line1     <= 4'd0;
      pipe1     <= STAGE_IDLE;
      vram_addr <= 10'd0;
    end else if (ce_pix) begin
      ld1   <= cell_start;
      line1 <= line_in_cell;
      pipe1 <= '{active: active_now, hs: hs_now, vs: vs_now,
                 wide: wide_line, phase: hsub[0]};
      if (cell_start) begin
        vram_addr <= {char_row, char_col};
      end
    end
  end

  // Stage 2: capture the character code and present the glyph ROM address
  always_ff @(posedge clk) begin
    if (reset) begin
      ld2     <= 1'b0;
      pipe2   <= STAGE_IDLE;
      block2  <= 1'b0;
      bits2   <= 6'd0;
      band2   <= 2'd0;
      cg_addr <= 11'd0;
    end else if (ce_pix) begin
      ld2   <= ld1;
      pipe2 <= pipe1;
      if (ld1) begin
        block2 <= fetched_code[7];
        bits2  <= fetched_code[5:0];
        band2  <= line1[3:2];
        if (!fetched_code[7]) begin
          cg_addr <= {fetched_code[6:0], line1};
        end
      end
    end
  end

  // Stage 3: carry the tick attributes alongside the shifter load
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe3 <= STAGE_IDLE;
    end else if (ce_pix) begin
      pipe3 <= pipe2;
    end
  end

  trs80_char_shifter u_shifter (
    .clk    (clk),
    .reset  (reset),
    .ce_pix (ce_pix),
    .load   (ld2),
    .block  (block2),
    .bits   (bits2),
    .band   (band2),
    .glyph  (cg_data),
    .wide   (pipe3.wide),
    .phase  (pipe3.phase),
    .pixel  (pixel)
  );

  // Output stage: register colour and syncs together so they stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      level <= BG_LEVEL;
    end else if (ce_pix) begin
      hs    <= pipe3.hs;
      vs    <= pipe3.vs;
      level <= (pipe3.active && pixel) ? FG_LEVEL : BG_LEVEL;
    end
  end

  assign r = level;
  assign g = level;
  assign b = level;

endmodule

// File: tb/tb_trs80_video_gen.sv
// tb_trs80_video_gen: scoreboard bench for trs80_video_gen. A raster model
// pushes the expected {hs, vs, r, g, b} for every pixel tick it drives;
// entries are popped three ticks later when the DUT shows that pixel.
module tb_trs80_video_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        wide;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] cg_addr;
  logic [5:0]  cg_data;
  logic        hs;
  logic        vs;
  logic [5:0]  r;
  logic [5:0]  g;
  logic [5:0]  b;

  int total = 0;
  int bad = 0;
  int vram_mode = 0;
  int cg_mode = 0;
  int mh = 0;
  int mv = 0;
  logic m_wide = 1'b0;
  logic [19:0] sb_q[$];
  logic [19:0] last_want;

  localparam logic [19:0] RESET_REC = 20'hC0000;

  trs80_video_gen dut (
    .clk       (clk),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .wide      (wide),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .cg_addr   (cg_addr),
    .cg_data   (cg_data),
    .hs        (hs),
    .vs        (vs),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  always #5 clk = ~clk;

  // Video RAM contents as a function of address for each test pattern
  function automatic logic [7:0] vram_fn(input logic [9:0] a, input int mode);
    logic [7:0] hsh;
    hsh = (a[7:0] * 8'd37 + 8'd11) ^ {a[9:8], 6'd0};
    case (mode)
      0: return 8'h41;
      1: return (a == 10'd0) ? 8'h81 : hsh;
      2: return 8'h61;
      default: return hsh;
    endcase
  endfunction

  // Character generator ROM contents for each test pattern
  function automatic logic [5:0] cg_fn(input logic [10:0] a, input int mode);
    if (mode == 0) return 6'b100001;
    return a[5:0] ^ a[10:5] ^ {a[3:0], 2'b01};
  endfunction

  assign vram_data = vram_fn(vram_addr, vram_mode);
  assign cg_data   = cg_fn(cg_addr, cg_mode);

  // Text codes on a stock machine have no independent bit 6
  function automatic logic [7:0] fix_code(input logic [7:0] c);
`ifdef LOWERCASE_MOD_EN
    return c;
`else
    return c[7] ? c : {1'b0, ~c[5], c[5:0]};
`endif
  endfunction

  // Expected {hs, vs, r, g, b} for raster position (h, v)
  function automatic logic [19:0] make_expect(input int h, input int v, input logic wl);
    logic hs_e, vs_e, fg;
    logic [7:0] code;
    logic [5:0] glyph;
    logic [5:0] lvl;
    int col, pix, row, line, idx;
    hs_e = !(h >= 416 && h < 464);
    vs_e = !(v >= 240 && v < 244);
    fg = 1'b0;
    if (h < 384 && v < 192) begin
      col  = wl ? (h / 12) * 2 : h / 6;
      pix  = wl ? (h % 12) / 2 : h % 6;
      row  = v / 12;
      line = v % 12;
      code = fix_code(vram_fn(10'(row * 64 + col), vram_mode));
      if (code[7]) begin
        idx = 2 * (line / 4) + ((pix >= 3) ? 1 : 0);
        fg  = code[idx];
      end else begin
        glyph = cg_fn({code[6:0], 4'(line)}, cg_mode);
        fg    = glyph[5 - pix];
      end
    end
    lvl = fg ? 6'd63 : 6'd0;
    return {hs_e, vs_e, lvl, lvl, lvl};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (model line %0d tick %0d)", tag, got, want, mv, mh);
    end
  endtask

  // Synchronous reset; the model restarts and the pipeline refills with idle entries
  task automatic doReset(input int cycles, input bit random_ce);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      ce_pix = random_ce ? 1'($urandom_range(0, 1)) : 1'(i % 2);
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    ce_pix = 1'b0;
    mh = 0;
    mv = 0;
    m_wide = 1'b0;
    sb_q.delete();
    repeat (3) sb_q.push_back(RESET_REC);
    last_want = RESET_REC;
    checkOutput("rst_out", {hs, vs, r, g, b}, RESET_REC);
    checkOutput("rst_vaddr", 20'(vram_addr), 20'd0);
    checkOutput("rst_cgaddr", 20'(cg_addr), 20'd0);
  endtask

  // One pixel tick, preceded by 'gaps' clocks with ce_pix low
  task automatic applyStimulus(input int gaps);
    logic [19:0] want;
    logic [7:0] code;
    int sub, col;
    for (int i = 0; i < gaps; i++) begin
      ce_pix = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("hold", {hs, vs, r, g, b}, last_want);
    end
    sb_q.push_back(make_expect(mh, mv, m_wide));
    ce_pix = 1'b1;
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    last_want = want;
    checkOutput("pixel", {hs, vs, r, g, b}, want);
    sub = m_wide ? mh % 12 : mh % 6;
    col = m_wide ? (mh / 12) * 2 : mh / 6;
    if (mh < 384 && mv < 192) begin
      if (sub == 0) begin
        checkOutput("vram_addr", 20'(vram_addr), 20'({4'(mv / 12), 6'(col)}));
      end else if (sub == 1) begin
        code = fix_code(vram_fn(10'((mv / 12) * 64 + col), vram_mode));
        if (!code[7]) begin
          checkOutput("cg_addr", 20'(cg_addr), 20'({code[6:0], 4'(mv % 12)}));
        end
      end
    end
    if (mh == 511) begin
      m_wide = wide;
      mh = 0;
      mv = (mv == 311) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    ce_pix = 1'b0;
    wide   = 1'b0;
    $display("[TB] starting");

    // Uniform 'A' glyph with columns 0 and 5 lit, ce one clock in two
    vram_mode = 0;
    cg_mode   = 0;
    doReset(2, 1'b0);
    repeat (3 * 512) applyStimulus(1);

    // Block graphic 0x81 at row 0 col 0 among mixed codes
    vram_mode = 1;
    cg_mode   = 1;
    doReset(2, 1'b0);
    repeat (4 * 512) applyStimulus(0);

    // Lowercase code 0x61 everywhere
    vram_mode = 2;
    doReset(2, 1'b0);
    repeat (520) applyStimulus(0);

    // Wide requested mid-line 0; takes effect from line 1
    vram_mode = 3;
    wide = 1'b0;
    doReset(2, 1'b0);
    while (!(mv == 3 && mh == 0)) begin
      if (mv == 0 && mh == 100) wide = 1'b1;
      applyStimulus(0);
    end

    // Run on to line 100 tick 200, reset there, restart with gapped ticks
    while (!(mv == 100 && mh == 200)) applyStimulus(0);
    doReset(3, 1'b1);
    repeat (2 * 512 + 16) applyStimulus(int'($urandom_range(0, 2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
